// File: rtl/fg_dac_pkg.sv
// Shared types and constants for the function-generator DAC write sequencer.
package fg_dac_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_SETUP  = 5'b00010,
        ST_STROBE = 5'b00100,
        ST_HOLD   = 5'b01000,
        ST_SETTLE = 5'b10000
    } state_e;

    localparam int unsigned CLK_FREQ_HZ       = 32'd50_000_000;
    localparam int unsigned DEF_SETTLE_CYCLES = 32'd500;
    localparam int          DEF_WR_WIDTH      = 32'sd2;
    localparam int          OVR_CNT_W         = 32'sd16;

    // A phase lasting n cycles loads n-1; zero-length requests still take one cycle.
    function automatic int unsigned phase_load(input int unsigned cycles);
        if (cycles == 32'd0) begin
            return 32'd0;
        end else begin
            return cycles - 32'd1;
        end
    endfunction

endpackage

// File: rtl/fg_dac_write_sequencer_if.sv
// Generator-to-DAC bus bundle; overrun_cnt exists only with FG_DAC_OVERRUN_CNT_EN.
interface fg_dac_write_sequencer_if #(
    parameter int BITWIDTH        = 8,
    parameter int SETTLE_BITWIDTH = 16
);
    import fg_dac_pkg::*;

    logic                       enable;
    logic [SETTLE_BITWIDTH-1:0] settle_cycles;
    logic [BITWIDTH-1:0]        sample;
    logic                       sample_valid;
    logic [BITWIDTH-1:0]        dac_data;
    logic                       dac_wr_n;
    logic                       dac_pd_n;
    logic                       dac_clr_n;
    logic                       busy;
    logic                       overrun;
`ifdef FG_DAC_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0]       overrun_cnt;

    modport master (
        output enable, settle_cycles, sample, sample_valid,
        input  dac_data, dac_wr_n, dac_pd_n, dac_clr_n, busy, overrun, overrun_cnt
    );
    modport slave (
        input  enable, settle_cycles, sample, sample_valid,
        output dac_data, dac_wr_n, dac_pd_n, dac_clr_n, busy, overrun, overrun_cnt
    );
`else
    modport master (
        output enable, settle_cycles, sample, sample_valid,
        input  dac_data, dac_wr_n, dac_pd_n, dac_clr_n, busy, overrun
    );
    modport slave (
        input  enable, settle_cycles, sample, sample_valid,
        output dac_data, dac_wr_n, dac_pd_n, dac_clr_n, busy, overrun
    );
`endif

endinterface

// File: rtl/fg_dac_timer.sv
// Loadable down-counter with zero flag, shared by all timed phases of the sequencer.
module fg_dac_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count down to zero and park there until reloaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != '0) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/fg_dac_write_sequencer.sv
// Parallel-DAC write sequencer: setup / strobe / hold / settle timing with a 1-deep pending sample.
// Optional saturating overrun counter enabled by FG_DAC_OVERRUN_CNT_EN.
module fg_dac_write_sequencer
    import fg_dac_pkg::*;
#(
    parameter int BITWIDTH        = 8,
    parameter int SETTLE_BITWIDTH = 16,
    parameter int SETUP_CYCLES    = 1,
    parameter int WR_WIDTH        = DEF_WR_WIDTH,
    parameter int HOLD_CYCLES     = 1
) (
    input logic                     clk,
    input logic                     rst,
    fg_dac_write_sequencer_if.slave bus
);

    localparam logic [SETTLE_BITWIDTH-1:0] SETUP_LOAD = SETTLE_BITWIDTH'(phase_load(SETUP_CYCLES));
    localparam logic [SETTLE_BITWIDTH-1:0] WR_LOAD    = SETTLE_BITWIDTH'(phase_load(WR_WIDTH));
    localparam logic [SETTLE_BITWIDTH-1:0] HOLD_LOAD  = SETTLE_BITWIDTH'(phase_load(HOLD_CYCLES));

    state_e                     state_r;
    state_e                     state_nx_s;
    logic                       tmr_load_s;
    logic [SETTLE_BITWIDTH-1:0] tmr_value_s;
    logic [SETTLE_BITWIDTH-1:0] settle_load_s;
    logic                       tmr_zero_s;
    logic                       start_s;

    logic [BITWIDTH-1:0]        data_r;
    logic [BITWIDTH-1:0]        pend_data_r;
    logic                       pend_valid_r;
    logic                       overrun_r;
    logic                       wr_n_r;
    logic                       pd_n_r;
    logic                       clr_n_r;
    logic                       busy_r;

    fg_dac_timer #(.WIDTH(SETTLE_BITWIDTH)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load_s),
        .load_value (tmr_value_s),
        .zero       (tmr_zero_s)
    );

    assign settle_load_s = (bus.settle_cycles == '0) ? '0
                                                     : bus.settle_cycles - SETTLE_BITWIDTH'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; each phase exit reloads the shared timer for the following phase
    always_comb begin
        state_nx_s  = state_r;
        tmr_load_s  = 1'b0;
        tmr_value_s = '0;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable && (bus.sample_valid || pend_valid_r)) begin
                    state_nx_s  = ST_SETUP;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = SETUP_LOAD;
                    start_s     = 1'b1;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_zero_s) begin
                    state_nx_s  = ST_STROBE;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = WR_LOAD;
                end else begin
                    state_nx_s  = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (tmr_zero_s) begin
                    state_nx_s  = ST_HOLD;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = HOLD_LOAD;
                end else begin
                    state_nx_s  = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (tmr_zero_s) begin
                    state_nx_s  = ST_SETTLE;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = settle_load_s;
                end else begin
                    state_nx_s  = ST_HOLD;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SETTLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Data capture and pending buffer; the newest sample always wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r       <= '0;
            pend_data_r  <= '0;
            pend_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (start_s) begin
                data_r       <= bus.sample_valid ? bus.sample : pend_data_r;
                pend_valid_r <= 1'b0;
            end else if (!bus.enable) begin
                pend_valid_r <= 1'b0;
            end else if (bus.sample_valid && (state_r != ST_IDLE)) begin
                pend_data_r  <= bus.sample;
                pend_valid_r <= 1'b1;
                overrun_r    <= pend_valid_r;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    // Pin flops decoded from the next state so every output leaves a register directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_n_r  <= 1'b1;
            pd_n_r  <= 1'b0;
            clr_n_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            wr_n_r  <= (state_nx_s != ST_STROBE);
            pd_n_r  <= bus.enable || (state_nx_s != ST_IDLE);
            clr_n_r <= 1'b1;
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    assign bus.dac_data  = data_r;
    assign bus.dac_wr_n  = wr_n_r;
    assign bus.dac_pd_n  = pd_n_r;
    assign bus.dac_clr_n = clr_n_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;

`ifdef FG_DAC_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_r;

    // Saturating count of overrun pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_cnt_r <= '0;
        end else if (overrun_r && (ovr_cnt_r != '1)) begin
            ovr_cnt_r <= ovr_cnt_r + OVR_CNT_W'(1);
        end else begin
            ovr_cnt_r <= ovr_cnt_r;
        end
    end

    assign bus.overrun_cnt = ovr_cnt_r;
`endif

endmodule

// File: tb/tb_fg_dac_write_sequencer.sv
// Randomized bench for fg_dac_write_sequencer against a transaction-timing reference model.
module tb_fg_dac_write_sequencer;
    import fg_dac_pkg::*;

    localparam int BW  = 8;
    localparam int SW  = 16;
    localparam int SU  = 1;
    localparam int WW  = 2;
    localparam int HC  = 1;
    localparam int BIG = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fg_dac_write_sequencer_if #(.BITWIDTH(BW), .SETTLE_BITWIDTH(SW)) bus ();

    fg_dac_write_sequencer #(
        .BITWIDTH(BW), .SETTLE_BITWIDTH(SW), .SETUP_CYCLES(SU), .WR_WIDTH(WW), .HOLD_CYCLES(HC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    // Reference model: each write is a window [start, start+len) of edges; len known once settle is sampled
    int           edge_k     = 0;
    int           cur_start  = 0;
    int           cur_len    = 0;
    int           next_start = 0;
    logic         started    = 1'b0;
    logic [BW-1:0] cur_data  = '0;
    logic [BW-1:0] pend_d    = '0;
    logic         pend_v     = 1'b0;
    logic         ovr_exp    = 1'b0;
    int           cnt_exp    = 0;
    int           writes     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_k);
        end
    endtask

    task automatic model_reset();
        edge_k = 0; cur_start = 0; cur_len = 0; next_start = 0;
        started = 1'b0; cur_data = '0; pend_d = '0; pend_v = 1'b0; ovr_exp = 1'b0; cnt_exp = 0;
    endtask

    task automatic model_edge(input logic en, input logic valid, input logic [BW-1:0] smp,
                              input logic [SW-1:0] settle);
        logic prev_ovr;
        prev_ovr = ovr_exp;
        if (started && (edge_k - cur_start) == SU + WW + HC) begin
            cur_len    = SU + WW + HC + ((settle == 16'd0) ? 1 : int'(settle));
            next_start = cur_start + cur_len + 1;
        end
        ovr_exp = 1'b0;
        if (edge_k >= next_start && en && (valid || pend_v)) begin
            cur_data   = valid ? smp : pend_d;
            pend_v     = 1'b0;
            started    = 1'b1;
            cur_start  = edge_k;
            cur_len    = BIG;
            next_start = BIG;
            writes++;
        end else if (!en) begin
            pend_v = 1'b0;
        end else if (valid && edge_k < next_start) begin
            ovr_exp = pend_v;
            pend_v  = 1'b1;
            pend_d  = smp;
        end
        if (prev_ovr && cnt_exp < 65535) cnt_exp++;
        edge_k++;
    endtask

    task automatic step(input logic en, input logic valid, input logic [BW-1:0] smp,
                        input logic [SW-1:0] settle);
        int   o;
        logic busy_e;
        logic wrn_e;
        bus.enable        = en;
        bus.sample_valid  = valid;
        bus.sample        = smp;
        bus.settle_cycles = settle;
        @(posedge clk);
        model_edge(en, valid, smp, settle);
        @(negedge clk);
        o      = (edge_k - 1) - cur_start;
        busy_e = started && (o < cur_len);
        wrn_e  = !(started && o >= SU && o < SU + WW);
        check_val("dac_data", 32'(bus.dac_data), 32'(cur_data));
        check_val("dac_wr_n", 32'(bus.dac_wr_n), 32'(wrn_e));
        check_val("busy", 32'(bus.busy), 32'(busy_e));
        check_val("dac_pd_n", 32'(bus.dac_pd_n), 32'(en || busy_e));
        check_val("dac_clr_n", 32'(bus.dac_clr_n), 32'd1);
        check_val("overrun", 32'(bus.overrun), 32'(ovr_exp));
`ifdef FG_DAC_OVERRUN_CNT_EN
        check_val("overrun_cnt", 32'(bus.overrun_cnt), 32'(cnt_exp));
`endif
    endtask

    task automatic idle_steps(input int n, input logic [SW-1:0] settle);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, settle);
    endtask

    initial begin
        bus.enable = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0; bus.settle_cycles = '0;
        #1 rst = 1'b1;
        #1;
        check_val("rst_data", 32'(bus.dac_data), 32'h0);
        check_val("rst_wr_n", 32'(bus.dac_wr_n), 32'h1);
        check_val("rst_pd_n", 32'(bus.dac_pd_n), 32'h0);
        check_val("rst_clr_n", 32'(bus.dac_clr_n), 32'h0);
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        check_val("rst_overrun", 32'(bus.overrun), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_steps(2, 16'd3);

        // Single write, settle 3
        step(1'b1, 1'b1, 8'hA5, 16'd3);
        idle_steps(10, 16'd3);

        // 10 then 20, 30 while busy: 30 overwrites 20
        step(1'b1, 1'b1, 8'h10, 16'd3);
        step(1'b1, 1'b1, 8'h20, 16'd3);
        step(1'b1, 1'b1, 8'h30, 16'd3);
        idle_steps(20, 16'd3);
        check_val("cnt_overruns", 32'(cnt_exp), 32'd1);

        // Back-to-back valid with zero settle
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 16'd0);
        idle_steps(8, 16'd0);

        // Enable dropped during strobe with a sample pending
        step(1'b1, 1'b1, 8'h55, 16'd2);
        step(1'b1, 1'b1, 8'h66, 16'd2);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h77, 16'd2);
        idle_steps(6, 16'd2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), 16'($urandom_range(0, 4)));
        end
        idle_steps(12, 16'd1);

        // Asynchronous reset while the strobe is low
        step(1'b1, 1'b1, 8'hC3, 16'd3);
        step(1'b1, 1'b0, 8'h00, 16'd3);
        check_val("pre_rst_wr_n", 32'(bus.dac_wr_n), 32'h0);
        #2 rst = 1'b1;
        #1;
        check_val("async_wr_n", 32'(bus.dac_wr_n), 32'h1);
        check_val("async_data", 32'(bus.dac_data), 32'h0);
        check_val("async_busy", 32'(bus.busy), 32'h0);
        check_val("async_clr_n", 32'(bus.dac_clr_n), 32'h0);
        check_val("async_pd_n", 32'(bus.dac_pd_n), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_steps(3, 16'd3);
        step(1'b1, 1'b1, 8'h3C, 16'd1);
        idle_steps(8, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
